// File: rtl/circular_fifo_pkg.sv
// Shared definitions for the circular FIFO: depth helper, threshold
// legality checks and a status bundle for monitors.
package circular_fifo_pkg;

    function automatic int fifo_depth(input int aw);
        return 1 << aw;
    endfunction

    function automatic bit af_thresh_ok(input int th, input int aw);
        return (th >= 1) && (th <= fifo_depth(aw));
    endfunction

    function automatic bit ae_thresh_ok(input int th, input int aw);
        return (th >= 0) && (th <= fifo_depth(aw) - 1);
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port register array: synchronous write, asynchronous read.
// Contents are deliberately not reset.
module fifo_mem #(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/circular_fifo.sv
// Circular FIFO with occupancy level, programmable thresholds, sticky
// error flags, synchronous flush and optional first-word-fall-through.
module circular_fifo
    import circular_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_THRESH  = fifo_depth(ADDR_WIDTH) - 2,
    parameter int AE_THRESH  = 1,
    parameter bit FWFT       = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] DEPTH_L = PW'(fifo_depth(ADDR_WIDTH));
    localparam logic [PW-1:0] AF_L    = PW'(AF_THRESH);
    localparam logic [PW-1:0] AE_L    = PW'(AE_THRESH);
    localparam fifo_status_t ST_RST = '{
        full: 1'b0, empty: 1'b1, almost_full: 1'b0,
        almost_empty: 1'b1, overflow: 1'b0, underflow: 1'b0
    };

    if (!af_thresh_ok(AF_THRESH, ADDR_WIDTH)) begin : g_bad_af
        $error("circular_fifo: AF_THRESH outside 1..DEPTH");
    end
    if (!ae_thresh_ok(AE_THRESH, ADDR_WIDTH)) begin : g_bad_ae
        $error("circular_fifo: AE_THRESH outside 0..DEPTH-1");
    end

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         level_d;
    fifo_status_t          st_q, st_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic [DATA_WIDTH-1:0] head;
    logic                  wr_acc, rd_acc;

    assign wr_acc = wr_en && !st_q.full;
    assign rd_acc = rd_en && !st_q.empty;

    fifo_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_mem (
        .clk_i  (clk),
        .we_i   (wr_acc && !clr && !rst),
        .waddr_i(wr_ptr_q[ADDR_WIDTH-1:0]),
        .wdata_i(wr_data),
        .raddr_i(rd_ptr_q[ADDR_WIDTH-1:0]),
        .rdata_o(head)
    );

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        st_d       = st_q;
        if (clr) begin
            wr_ptr_d       = '0;
            rd_ptr_d       = '0;
            st_d.overflow  = 1'b0;
            st_d.underflow = 1'b0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + PW'(1);
            if (wr_en && st_q.full) st_d.overflow = 1'b1;
            if (rd_acc) begin
                rd_ptr_d   = rd_ptr_q + PW'(1);
                rd_valid_d = 1'b1;
                rd_data_d  = head;
            end
            if (rd_en && st_q.empty) st_d.underflow = 1'b1;
        end
        // Flags are registered from the post-edge occupancy.
        level_d           = wr_ptr_d - rd_ptr_d;
        st_d.full         = (level_d == DEPTH_L);
        st_d.empty        = (level_d == '0);
        st_d.almost_full  = (level_d >= AF_L);
        st_d.almost_empty = (level_d <= AE_L);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            st_q       <= ST_RST;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            st_q       <= st_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign level        = wr_ptr_q - rd_ptr_q;
    assign full         = st_q.full;
    assign empty        = st_q.empty;
    assign almost_full  = st_q.almost_full;
    assign almost_empty = st_q.almost_empty;
    assign overflow     = st_q.overflow;
    assign underflow    = st_q.underflow;
    assign rd_data      = FWFT ? head : rd_data_q;
    assign rd_valid     = FWFT ? !st_q.empty : rd_valid_q;

endmodule

// File: tb/tb_circular_fifo.sv
// Directed bench for circular_fifo: registered-read instance and FWFT instance.
module tb_circular_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        a_clr = 0, a_wr = 0, a_rd = 0;
    logic [11:0] a_wd = '0;
    logic [11:0] a_rdata;
    logic        a_rv, a_full, a_empty, a_af, a_ae, a_ov, a_un;
    logic [4:0]  a_lvl;

    logic        b_clr = 0, b_wr = 0, b_rd = 0;
    logic [11:0] b_wd = '0;
    logic [11:0] b_rdata;
    logic        b_rv, b_full, b_empty, b_af, b_ae, b_ov, b_un;
    logic [4:0]  b_lvl;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    circular_fifo #(.DATA_WIDTH(12), .ADDR_WIDTH(4), .FWFT(1'b0)) u_a (
        .clk(clk), .rst(rst), .clr(a_clr),
        .wr_en(a_wr), .wr_data(a_wd), .rd_en(a_rd),
        .rd_data(a_rdata), .rd_valid(a_rv),
        .full(a_full), .empty(a_empty),
        .almost_full(a_af), .almost_empty(a_ae),
        .level(a_lvl), .overflow(a_ov), .underflow(a_un)
    );

    circular_fifo #(.DATA_WIDTH(12), .ADDR_WIDTH(4), .FWFT(1'b1)) u_b (
        .clk(clk), .rst(rst), .clr(b_clr),
        .wr_en(b_wr), .wr_data(b_wd), .rd_en(b_rd),
        .rd_data(b_rdata), .rd_valid(b_rv),
        .full(b_full), .empty(b_empty),
        .almost_full(b_af), .almost_empty(b_ae),
        .level(b_lvl), .overflow(b_ov), .underflow(b_un)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;

        chk("rst_level", a_lvl, 0);
        chk("rst_empty", a_empty, 1);
        chk("rst_full", a_full, 0);
        chk("rst_ae", a_ae, 1);
        chk("rst_af", a_af, 0);
        chk("rst_ov", a_ov, 0);
        chk("rst_un", a_un, 0);
        chk("rst_rv", a_rv, 0);
        chk("rst_rdata", a_rdata, 0);
        chk("b_rst_rv", b_rv, 0);
        chk("b_rst_empty", b_empty, 1);

        // FWFT instance
        b_wr = 1; b_wd = 12'h123;
        tick();
        b_wr = 0;
        chk("b_rv_first", b_rv, 1);
        chk("b_data_first", b_rdata, 12'h123);
        b_wr = 1; b_wd = 12'h456;
        tick();
        b_wr = 0;
        chk("b_head_hold", b_rdata, 12'h123);
        chk("b_lvl2", b_lvl, 2);
        b_rd = 1;
        tick();
        b_rd = 0;
        chk("b_pop1_data", b_rdata, 12'h456);
        chk("b_pop1_rv", b_rv, 1);
        chk("b_pop1_lvl", b_lvl, 1);
        b_rd = 1;
        tick();
        b_rd = 0;
        chk("b_pop2_rv", b_rv, 0);
        chk("b_pop2_empty", b_empty, 1);
        b_rd = 1; b_wr = 1; b_wd = 12'h0AA;
        tick();
        b_rd = 0; b_wr = 0;
        chk("b_unf", b_un, 1);
        chk("b_unf_wr_lvl", b_lvl, 1);
        chk("b_unf_wr_data", b_rdata, 12'h0AA);
        chk("b_unf_ov", b_ov, 0);
        chk("b_unf_full", b_full, 0);
        chk("b_unf_af", b_af, 0);
        chk("b_unf_ae", b_ae, 1);

        // fill
        for (int i = 1; i <= 16; i++) begin
            a_wr = 1; a_wd = 12'(i);
            tick();
            chk("fill_lvl", a_lvl, i);
            chk("fill_full", a_full, (i == 16) ? 1 : 0);
            chk("fill_af", a_af, (i >= 14) ? 1 : 0);
            chk("fill_ae", a_ae, (i <= 1) ? 1 : 0);
            chk("fill_empty", a_empty, 0);
        end
        a_wd = 12'hABC;
        tick();
        a_wr = 0;
        chk("ovf_flag", a_ov, 1);
        chk("ovf_lvl", a_lvl, 16);
        chk("ovf_full", a_full, 1);

        // drain
        for (int i = 1; i <= 16; i++) begin
            a_rd = 1;
            tick();
            a_rd = 0;
            chk("drain_rv", a_rv, 1);
            chk("drain_data", a_rdata, i);
            chk("drain_lvl", a_lvl, 16 - i);
            chk("drain_ae", a_ae, (16 - i <= 1) ? 1 : 0);
            tick();
            chk("drain_rv_pulse", a_rv, 0);
        end
        chk("drain_empty", a_empty, 1);

        a_rd = 1;
        tick();
        a_rd = 0;
        chk("unf_flag", a_un, 1);
        chk("unf_rv", a_rv, 0);
        chk("unf_lvl", a_lvl, 0);
        chk("unf_rdata_hold", a_rdata, 12'h010);
        chk("unf_ov_sticky", a_ov, 1);

        a_clr = 1;
        tick();
        a_clr = 0;
        chk("clr_ov", a_ov, 0);
        chk("clr_un", a_un, 0);
        chk("clr_empty", a_empty, 1);
        chk("clr_rdata_kept", a_rdata, 12'h010);

        // simultaneous read/write at level 5
        for (int k = 0; k < 5; k++) begin
            a_wr = 1; a_wd = 12'(12'h100 + k);
            tick();
        end
        a_wr = 0;
        chk("sim_pre_lvl", a_lvl, 5);
        for (int c = 0; c < 40; c++) begin
            a_wr = 1; a_rd = 1; a_wd = 12'(12'h105 + c);
            tick();
            chk("sim_lvl", a_lvl, 5);
            chk("sim_rv", a_rv, 1);
            chk("sim_data", a_rdata, 12'h100 + c);
        end
        a_wr = 0; a_rd = 0;

        for (int k = 0; k < 11; k++) begin
            a_wr = 1; a_wd = 12'(12'h200 + k);
            tick();
        end
        a_wr = 0;
        chk("refill_full", a_full, 1);
        a_wr = 1; a_rd = 1; a_wd = 12'h3FF;
        tick();
        a_wr = 0; a_rd = 0;
        chk("fullrw_lvl", a_lvl, 15);
        chk("fullrw_ov", a_ov, 1);
        chk("fullrw_rv", a_rv, 1);
        chk("fullrw_data", a_rdata, 12'h128);
        chk("fullrw_full", a_full, 0);

        // flush and reset mid-operation
        a_clr = 1;
        tick();
        a_clr = 0;
        for (int k = 0; k < 9; k++) begin
            a_wr = 1; a_wd = 12'(12'h050 + k);
            tick();
        end
        a_wr = 0;
        chk("mid_lvl9", a_lvl, 9);
        a_clr = 1; a_wr = 1; a_wd = 12'h777;
        tick();
        a_clr = 0; a_wr = 0;
        chk("clrwr_lvl", a_lvl, 0);
        chk("clrwr_empty", a_empty, 1);
        tick();
        chk("clrwr_lvl_after", a_lvl, 0);

        for (int k = 0; k < 9; k++) begin
            a_wr = 1; a_wd = 12'(12'h060 + k);
            tick();
        end
        a_wr = 0;
        chk("mid2_lvl9", a_lvl, 9);
        rst = 1; a_wr = 1; a_wd = 12'h777;
        tick();
        rst = 0; a_wr = 0;
        chk("rstwr_lvl", a_lvl, 0);
        chk("rstwr_empty", a_empty, 1);
        chk("rstwr_rdata", a_rdata, 0);

        a_wr = 1; a_wd = 12'h055;
        tick();
        a_wr = 0;
        chk("post_lvl", a_lvl, 1);
        chk("post_empty", a_empty, 0);
        a_rd = 1;
        tick();
        a_rd = 0;
        chk("post_rv", a_rv, 1);
        chk("post_data", a_rdata, 12'h055);
        chk("post_empty2", a_empty, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/circular_fifo.md
Name: circular_fifo

Overview:
Parametrised successor to the team's single-channel circular buffer. All 2**ADDR_WIDTH entries are usable and the pointers are correctly reset. The block adds:
- an occupancy count and programmable almost-full/almost-empty thresholds;
- sticky overflow/underflow error flags and a synchronous flush;
- a selectable first-word-fall-through (FWFT) read mode.

It sits between sample producers (ADC/filter stages) and slower consumers in the datapath.

Parameters:
DATA_WIDTH, 12, word width in bits
ADDR_WIDTH, 4, log2 of depth; DEPTH = 2**ADDR_WIDTH
AF_THRESH, DEPTH-2, almost_full asserted when level >= AF_THRESH; legal range 1..DEPTH
AE_THRESH, 1, almost_empty asserted when level <= AE_THRESH; legal range 0..DEPTH-1
FWFT, 0, 0 = registered read (1-cycle latency); 1 = head word always presented on rd_data

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset, synchronous, active-high
clr  in  1  synchronous flush
wr_en  in  1  write request
wr_data  in  DATA_WIDTH  write word
rd_en  in  1  read/pop request
rd_data  out  DATA_WIDTH  read word
rd_valid  out  1  rd_data valid (see Behaviour)
full  out  1  level == DEPTH
empty  out  1  level == 0
almost_full  out  1  level >= AF_THRESH
almost_empty  out  1  level <= AE_THRESH
level  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
overflow  out  1  sticky: a write was attempted while full
underflow  out  1  sticky: a read was attempted while empty

Behaviour:
- Reset values, and values on the edge after rst=1:
  - write/read pointers = 0, level = 0;
  - empty = 1, full = 0, almost_empty = 1, almost_full = 0;
  - overflow = 0, underflow = 0, rd_valid = 0, rd_data = 0.
  - Memory contents are not reset.
- Priority: rst > clr > wr/rd. clr has the same effect as rst on pointers, level, flags and rd_valid. clr does not clear rd_data in FWFT=0 mode.
- Pointers are ADDR_WIDTH+1 bits. The extra MSB distinguishes full from empty. Pointers wrap from DEPTH-1 to 0 with no lost entry.
- Write accepted iff wr_en && !full. The word is stored at wr_ptr and the pointer is incremented on the same edge.
- Write attempted while full: discarded, overflow set to 1 (sticky), nothing else changes. This applies even if rd_en is asserted in the same cycle.
- Read accepted iff rd_en && !empty.
- Read attempted while empty: underflow set to 1 (sticky), rd_valid = 0, nothing else changes. This applies even if wr_en is asserted in the same cycle.
- Simultaneous accepted read and write: both pointers advance and level is unchanged.
- All status outputs are registered and are functions of level after the edge. Flags update on the edge of the accepted operation, so a word written into an empty FIFO deasserts empty on the next edge.
- FWFT=0 read path:
  - On an accepted read, rd_data <= mem[rd_ptr] and rd_valid pulses 1 for exactly one cycle, on the cycle after rd_en.
  - Otherwise rd_valid = 0 and rd_data holds its last value.
- FWFT=1 read path:
  - rd_data = mem[rd_ptr] (combinational from the array) and rd_valid = !empty.
  - rd_en pops the head. The next word is visible in the cycle after the pop.
- level is always (wr_ptr - rd_ptr) mod 2**(ADDR_WIDTH+1), and never exceeds DEPTH.
- Illegal threshold parameters are reported by an elaboration-time assertion; there is no runtime check.

Decomposition:
- Package circular_fifo_pkg holds:
  - the localparam function for DEPTH;
  - threshold legality check functions;
  - a status struct typedef {full, empty, almost_full, almost_empty, overflow, underflow}, for reuse by monitors.
- One sub-module, fifo_mem: a simple dual-port register array with a synchronous write and an asynchronous read, parametrised on DATA_WIDTH/ADDR_WIDTH.
- circular_fifo holds the pointers, level, flags and the read output stage.

Test Plan:
- Fill/drain (DW=12, AW=4, FWFT=0):
  - Write 0x001..0x010 → full=1 after the 16th write, level=16, almost_full=1 from level 14.
  - Read 16 words → values 0x001..0x010 in order, each with rd_valid 1 cycle after rd_en; then empty=1.
- Overflow/underflow:
  - With FIFO full, write 0xABC → overflow=1, level stays 16, 0xABC is never read back.
  - With FIFO empty, pulse rd_en → underflow=1, rd_valid=0.
  - clr → both flags 0.
- Simultaneous read/write:
  - At level 5, assert wr_en and rd_en for 40 cycles with incrementing data → level stays 5, output sequence is contiguous, pointers wrap at least twice.
  - At full, assert both → read accepted, write rejected, overflow=1, level 15.
- FWFT=1:
  - Write 0x123 into empty FIFO → next cycle rd_valid=1 and rd_data=0x123 without rd_en.
  - Pop → rd_valid=0, empty=1.
- Flush/reset mid-operation:
  - At level 9, assert clr together with wr_en → level=0, empty=1, and the write is ignored.
  - Repeat with rst → identical result.
  - Then write 0x055 and read it → reads back 0x055.
